// File: rtl/seg_display_pkg.sv
// Shared constants, hex font and scan state for the seven-segment scanner.
// Optional feature macro: SEG_ADDR_OVERLAY_EN (used by seg_scan_display).
package seg_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    // Active-low gfedcba, entry 15 listed first
    localparam logic [15:0][6:0] HEX_FONT = {
        7'h0E, 7'h06, 7'h21, 7'h46,
        7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19,
        7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic {
        BLANK,
        DRIVE
    } scan_state_t;

endpackage

// File: rtl/seg_scan_display_hex_to_seg7.sv
// Combinational nibble to active-low seven-segment decoder.
// A set blank flag forces all segments off.
import seg_display_pkg::*;

module hex_to_seg7 (
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? SEG_BLANK : HEX_FONT[nibble];

endmodule

// File: rtl/seg_scan_display.sv
// Eight-digit hex scanner with per-frame snapshot and anti-ghost blanking.
// Define SEG_ADDR_OVERLAY_EN to show the RAM address on digits 7:6.
import seg_display_pkg::*;

module seg_scan_display #(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int DIGITS       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ram_data,
    input  logic        ram_data_valid,
    input  logic [9:0]  ram_addr,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [31:0]   snap;
    logic          wrap;
    logic          frame_end;
    logic [3:0]    nib;
    logic          sup;
    logic [6:0]    seg_dec;
    scan_state_t   state_q;
    scan_state_t   state_d;

    assign wrap      = cnt == CW'(SCAN_DIV - 1);
    assign frame_end = wrap && (idx == 3'(DIGITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            idx  <= '0;
            snap <= '0;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            if (wrap)
                idx <= idx + 1'b1;
            if (frame_end && ram_data_valid)
                snap <= ram_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= BLANK;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BLANK: if (cnt == CW'(BLANK_CYCLES - 1)) state_d = DRIVE;
            DRIVE: if (wrap) state_d = BLANK;
            default: state_d = BLANK;
        endcase
    end

`ifdef SEG_ADDR_OVERLAY_EN
    logic [9:0] snap_addr;
    logic       unused_addr;

    assign unused_addr = ^snap_addr[9:8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            snap_addr <= '0;
        else if (frame_end && ram_data_valid)
            snap_addr <= ram_addr;
    end

    // Address digits are never suppressed; data uses the low 24 bits
    always_comb begin
        nib = snap[{idx, 2'b00} +: 4];
        sup = (idx != 3'd0) && ((snap[23:0] >> {idx, 2'b00}) == 24'd0);
        if (idx == 3'd7) begin
            nib = snap_addr[7:4];
            sup = 1'b0;
        end else if (idx == 3'd6) begin
            nib = snap_addr[3:0];
            sup = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dp <= 1'b1;
        else
            dp <= !(state_q == DRIVE && idx == 3'd6);
    end
`else
    logic unused_addr;

    assign unused_addr = ^ram_addr;
    assign dp          = 1'b1;

    always_comb begin
        nib = snap[{idx, 2'b00} +: 4];
        sup = (idx != 3'd0) && ((snap >> {idx, 2'b00}) == 32'd0);
    end
`endif

    hex_to_seg7 u_font (
        .nibble(nib),
        .blank (sup),
        .seg   (seg_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
        end else if (state_q == DRIVE) begin
            an  <= ~(8'b1 << idx);
            seg <= seg_dec;
        end else begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed self-checking bench for seg_scan_display (SCAN_DIV=4, BLANK_CYCLES=1).
// Build with SEG_ADDR_OVERLAY_EN to exercise the address overlay instead.
module tb_seg_scan_display;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ram_data = 32'h0;
    logic        ram_data_valid = 1'b1;
    logic [9:0]  ram_addr = 10'h0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int checks = 0;
    int errors = 0;

    seg_scan_display #(
        .SCAN_DIV    (4),
        .BLANK_CYCLES(1),
        .DIGITS      (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ram_data      (ram_data),
        .ram_data_valid(ram_data_valid),
        .ram_addr      (ram_addr),
        .an            (an),
        .seg           (seg),
        .dp            (dp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One digit period: 1 blank sample then 3 driven samples
    task automatic check_digit(input string tag, input int d,
                               input logic [6:0] exp_seg, input logic exp_dp);
        logic [7:0] exp_an;
        exp_an = ~(8'b1 << d);
        @(negedge clk);
        check($sformatf("%s d%0d blank an", tag, d), 32'(an), 32'hFF);
        check($sformatf("%s d%0d blank seg", tag, d), 32'(seg), 32'h7F);
        check($sformatf("%s d%0d blank dp", tag, d), 32'(dp), 32'h1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("%s d%0d an", tag, d), 32'(an), 32'(exp_an));
            check($sformatf("%s d%0d seg", tag, d), 32'(seg), 32'(exp_seg));
            check($sformatf("%s d%0d dp", tag, d), 32'(dp), 32'(exp_dp));
        end
    endtask

    task automatic check_digits(input string tag, input int lo, input int hi,
                                input logic [7:0][6:0] exp,
                                input logic [7:0] exp_dp);
        for (int d = lo; d <= hi; d++)
            check_digit(tag, d, exp[d], exp_dp[d]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " an"}, 32'(an), 32'hFF);
        check({tag, " seg"}, 32'(seg), 32'h7F);
        check({tag, " dp"}, 32'(dp), 32'h1);
    endtask

    localparam logic [6:0] B = 7'h7F;

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

`ifdef SEG_ADDR_OVERLAY_EN
        ram_addr = 10'h01F;
        ram_data = 32'h0000_0005;
        check_digits("ovl0", 0, 7,
                     {7'h40, 7'h40, B, B, B, B, B, 7'h40}, 8'hBF);
        check_digits("ovl1", 0, 7,
                     {7'h79, 7'h0E, B, B, B, B, B, 7'h12}, 8'hBF);
`else
        ram_data = 32'h0000_0A18;
        check_digits("zero", 0, 7, {B, B, B, B, B, B, B, 7'h40}, 8'hFF);
        ram_data = 32'h1111_1111;
        check_digits("supp", 0, 7,
                     {B, B, B, B, B, 7'h08, 7'h79, 7'h00}, 8'hFF);
        check_digits("tear", 0, 3, {8{7'h79}}, 8'hFF);
        ram_data = 32'hFFFF_FFFF;
        check_digits("tear", 4, 7, {8{7'h79}}, 8'hFF);
        ram_data_valid = 1'b0;
        ram_data = 32'h0000_0005;
        check_digits("allf", 0, 7, {8{7'h0E}}, 8'hFF);
        ram_data_valid = 1'b1;
        ram_data = 32'h1234_5678;
        check_digits("hold", 0, 7, {8{7'h0E}}, 8'hFF);
        check_digits("font", 0, 7,
                     {7'h79, 7'h24, 7'h30, 7'h19,
                      7'h12, 7'h02, 7'h78, 7'h00}, 8'hFF);
`endif

        // Mid-digit asynchronous reset, then restart from digit 0 with snap=0
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async");
        @(negedge clk);
        check_reset_outputs("held");
        rst_n = 1'b1;
`ifdef SEG_ADDR_OVERLAY_EN
        check_digits("rst", 0, 7,
                     {7'h40, 7'h40, B, B, B, B, B, 7'h40}, 8'hBF);
`else
        check_digits("rst", 0, 7, {B, B, B, B, B, B, B, 7'h40}, 8'hFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Time-multiplexed seven-segment scanner: the read side of the external-RAM display path. It takes the word returned from the external RAM at the address the display address controller drives, snapshots it once per scan frame, and scans it as hexadecimal across eight common-anode digits. It sits between the external RAM data output and the board's anode and segment pins.

## Interface
- `SCAN_DIV`, 100000: clock cycles each digit is selected; must be ≥ 2.
- `BLANK_CYCLES`, 1000: cycles at the start of each digit period with all anodes off (anti-ghosting); must be < `SCAN_DIV`.
- `DIGITS`, 8: number of digits; fixed at 8 for a 32-bit word.
- `clk` input 1: single clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `ram_data` input 32: word read from external RAM.
- `ram_data_valid` input 1: `ram_data` is stable and may be captured.
- `ram_addr` input 10: address currently applied to the RAM.
- `an` output 8: digit anodes, active-low, registered.
- `seg` output 7: segments `{g,f,e,d,c,b,a}`, active-low, registered.
- `dp` output 1: decimal point, active-low, registered.

## Operation
- Counter `cnt` runs 0..`SCAN_DIV`-1. Digit index `idx` runs 0..7.
- When `cnt` = `SCAN_DIV`-1:
  - `cnt` goes to 0 and `idx` goes to (`idx`+1) mod 8.
  - If `idx` = 7 and `ram_data_valid` = 1, `snap` ← `ram_data` and `snap_addr` ← `ram_addr`.
  - If `ram_data_valid` = 0, the snapshot holds its old value.
- Two-state digit FSM, re-entered every digit period:
  - BLANK while `cnt` < `BLANK_CYCLES`.
  - DRIVE otherwise.
  - BLANK → DRIVE when `cnt` = `BLANK_CYCLES`-1. DRIVE → BLANK on the `cnt` wrap.
- BLANK outputs: `an` = 8'hFF, `seg` = 7'h7F, `dp` = 1.
- DRIVE outputs: `an` = ~(1 << `idx`), `seg` = decode(`snap`[4·idx+3 : 4·idx]).
- Leading-zero suppression: digit `idx` > 0 shows blank (7'h7F) if `snap`[31 : 4·idx] = 0. Digit 0 is never suppressed.
- Decode, active-low `gfedcba`: 0 = 7'h40, 1 = 7'h79, 8 = 7'h00, A = 7'h08, F = 7'h0E. The rest follows the standard hex font.
- Reset values:
  - Outputs: `an` = 8'hFF, `seg` = 7'h7F, `dp` = 1.
  - Internal state: `cnt` = 0, `idx` = 0, `snap` = 0, `snap_addr` = 0, FSM in BLANK.
- Reset asserted mid-frame forces all outputs to their reset values immediately (asynchronous). Scanning restarts from digit 0 with `snap` = 0.
- The snapshot is a whole-word capture at the frame boundary only. A `ram_data` change mid-frame never tears the display.

## Timing
- All outputs are registered. They reflect `cnt`, `idx` and `snap` with 1-cycle latency.
- Frame length is 8·`SCAN_DIV` cycles.
- A new snapshot first appears on digit 0 at the cycle after the wrap that captured it.
- No handshake back to RAM. `ram_data_valid` is sampled only on the frame-boundary cycle.

## Configuration
- Macro `SEG_ADDR_OVERLAY_EN`.
- Defined:
  - Digits 7:6 show `snap_addr`[7:0] in hex, never suppressed.
  - `dp` = 0 while digit 6 is driven, as the address/data separator.
  - Digits 5:0 show `snap`[23:0]. Suppression applies within `snap`[23:0] only.
- Undefined:
  - All eight digits show `snap`[31:0].
  - `dp` is constant 1.
  - `snap_addr` is not built.

## Structure
- Package `seg_display_pkg` holds:
  - `SEG_BLANK` = 7'h7F and `AN_OFF` = 8'hFF.
  - The 16-entry hex font constant.
  - The `scan_state_t` enum {BLANK, DRIVE}.
- Sub-module `hex_to_seg7`: purely combinational. Takes a 4-bit nibble and a blank flag, returns 7-bit active-low segments. Instantiated once and fed by the `idx` mux.

## Test plan
Bench parameters: `SCAN_DIV` = 4, `BLANK_CYCLES` = 1.
- Reset and font:
  - Stimulus: hold `rst_n` = 0, release, apply `ram_data` = 32'h0000_0000 with valid = 1.
  - Response: `an` = 8'hFF, `seg` = 7'h7F during reset. First frame shows only digit 0 = 7'h40, with `an` = 8'hFE during DRIVE. All other digits are blank.
- Full word and suppression:
  - Stimulus: `ram_data` = 32'h0000_0A18, valid = 1.
  - Response: from the second frame, digits 0,1,2 = 7'h00, 7'h79, 7'h08 (`an` = FE, FD, FB). Digits 3..7 are blank.
- Tear-free capture:
  - Stimulus: change `ram_data` from 32'h1111_1111 to 32'hFFFF_FFFF mid-frame.
  - Response: the remaining digits of that frame still show 7'h79. The next frame shows 7'h0E on all digits.
- Valid gating:
  - Stimulus: `ram_data_valid` = 0 across a frame boundary.
  - Response: the previous snapshot is redisplayed unchanged.
- Blanking window:
  - Stimulus: any data.
  - Response: every digit period starts with exactly 1 cycle of `an` = 8'hFF, followed by 3 driven cycles.
- Overlay (with `SEG_ADDR_OVERLAY_EN`):
  - Stimulus: `ram_addr` = 10'h01F, `ram_data` = 32'h0000_0005.
  - Response: digit 7 = 7'h79 (1), digit 6 = 7'h0E (F) with `dp` = 0, digit 0 = decode(5). Digits 5..1 are blank.
